// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, issues one-outstanding imem fetches and
// queues {instruction, pc} pairs for decode. `define FETCH_PERF_EN adds perf counters.
module fetch_queue #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [PC_W-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   fetch_pc, req_pc;
  logic [CW-1:0]     count;
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [31:0]       mem_data [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic              push, pop, fire;

  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst_data  = mem_data[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];
  assign pop        = inst_valid && inst_ready;
  assign fire       = imem_req && imem_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Requests are gated by free slots, so a returning response always fits.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        imem_req = !rst && (count < CW'(DEPTH)) && !redirect_valid;
        if (imem_req && imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = IDLE;
          push    = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      if (redirect_valid)  fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
      else if (fire)       fetch_pc <= fetch_pc + PC_W'(4);
      if (fire) req_pc <= fetch_pc;
      if (push) begin
        mem_data[wr_ptr] <= imem_rdata;
        mem_pc[wr_ptr]   <= req_pc;
      end
      // A flush wins over any same-cycle pop; the popped head is simply gone.
      if (redirect_valid) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (inst_ready && !inst_valid && (perf_bubble_cnt != '1))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a model issues expected {pc,data} entries and
// a separate monitor pops and compares them at each decode handshake.
module tb_fetch_queue;
  localparam int unsigned     PC_W     = 8;
  localparam int unsigned     DEPTH    = 2;
  localparam logic [PC_W-1:0] RESET_PC = 8'hF8;

  logic            clk, rst;
  logic            imem_req, imem_gnt, imem_rvalid;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            inst_valid, inst_ready;
  logic [31:0]     inst_data;
  logic [PC_W-1:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_bubble_cnt, perf_flush_cnt;
`endif

  fetch_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     data;
  } inst_t;

  inst_t           exp_q[$];
  int unsigned     n_cmp, n_err;
  int unsigned     cur_cnt;
  bit              pend, live;
  logic [PC_W-1:0] pend_addr, model_pc;
  int unsigned     delay_left;
  int unsigned     gnt_pct, rdy_pct, redir_pct, min_delay, max_delay;
  bit              redir_wait, redir_rv;
  int unsigned     m_bubble, m_flush;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the head at every decode handshake.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        cur_cnt = 0;
      end else begin
        cur_cnt = exp_q.size();
        check("inst_valid", inst_valid, (exp_q.size() != 0));
        if (inst_ready && exp_q.size() == 0) m_bubble++;
        if (inst_valid && inst_ready && exp_q.size() != 0) begin
          check("inst_pc", inst_pc, exp_q[0].pc);
          check("inst_data", inst_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Reference model of what happens at the coming rising edge.
  task automatic model_edge();
    inst_t item;
    check("imem_req", imem_req, (!pend && cur_cnt < DEPTH && !redirect_valid));
    if (imem_rvalid) begin
      if (live && !redirect_valid) begin
        item.pc   = pend_addr;
        item.data = imem_rdata;
        exp_q.push_back(item);
      end
      pend = 1'b0;
    end else if (pend && delay_left > 0) begin
      delay_left--;
    end
    if (imem_req && imem_gnt) begin
      check("imem_addr", imem_addr, model_pc);
      pend       = 1'b1;
      live       = 1'b1;
      pend_addr  = model_pc;
      delay_left = $urandom_range(max_delay, min_delay);
      model_pc   = model_pc + 8'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
      live     = 1'b0;
      model_pc = {redirect_pc[PC_W-1:2], 2'b00};
      m_flush++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    imem_gnt       = ($urandom_range(99) < gnt_pct);
    inst_ready     = ($urandom_range(99) < rdy_pct);
    imem_rvalid    = pend && (delay_left == 0);
    imem_rdata     = $urandom;
    redirect_valid = ($urandom_range(99) < redir_pct);
    redirect_pc    = PC_W'($urandom);
    if (redir_wait && pend && live && delay_left > 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = 8'h40;
      redir_wait     = 1'b0;
    end
    if (redir_rv && imem_rvalid && live) begin
      redirect_valid = 1'b1;
      redirect_pc    = 8'h43;
      redir_rv       = 1'b0;
    end
    #2;
    model_edge();
  endtask

  task automatic set_knobs(input int unsigned g, input int unsigned r, input int unsigned rd,
                           input int unsigned dmin, input int unsigned dmax);
    gnt_pct = g; rdy_pct = r; redir_pct = rd; min_delay = dmin; max_delay = dmax;
  endtask

  task automatic reset_model();
    exp_q.delete();
    pend = 1'b0; live = 1'b0; delay_left = 0;
    model_pc = RESET_PC;
    m_bubble = 0; m_flush = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst inst_valid", inst_valid, 1'b0);
    check("rst imem_req", imem_req, 1'b0);
    check("rst inst_data", inst_data, 32'h0);
    check("rst inst_pc", inst_pc, 8'h0);
`ifdef FETCH_PERF_EN
    check("rst perf_bubble", perf_bubble_cnt, 32'h0);
    check("rst perf_flush", perf_flush_cnt, 32'h0);
`endif
  endtask

  initial begin
    bit found;
    n_cmp = 0; n_err = 0; cur_cnt = 0;
    redir_wait = 1'b0; redir_rv = 1'b0;
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    reset_model();
    #2;
    check_reset_outputs();
    @(posedge clk); #1 rst = 1'b0;

    // Streaming with immediate responses: wraps 0xF8 -> 0xFC -> 0x00 -> 0x04.
    set_knobs(100, 100, 0, 0, 0);
    repeat (12) step();

    // Stall decode until full, then drain.
    set_knobs(100, 0, 0, 0, 0);
    repeat (8) step();
    set_knobs(100, 100, 0, 0, 0);
    repeat (8) step();

    // Redirect while waiting on a slow response: stale word must be discarded.
    set_knobs(100, 100, 0, 2, 2);
    redir_wait = 1'b1;
    repeat (14) step();

    // Misaligned redirect coincident with the response.
    set_knobs(100, 100, 0, 0, 0);
    redir_rv = 1'b1;
    repeat (10) step();

    // Random traffic.
    set_knobs(70, 60, 5, 0, 3);
    repeat (1500) step();

    // Asynchronous reset while a fetch is outstanding and the FIFO holds data.
    set_knobs(100, 0, 0, 2, 3);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (pend && exp_q.size() >= 1) found = 1'b1;
    end
    if (!found) begin
      n_cmp++; n_err++;
      $display("FAIL reach_wait: got no outstanding fetch with queued data, expected one within 40 cycles");
    end
    @(negedge clk);
    imem_rvalid = 1'b0; imem_gnt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    #3 rst = 1'b1;
    reset_model();
    #1;
    check_reset_outputs();
    @(posedge clk); #1 rst = 1'b0;
    set_knobs(100, 100, 0, 0, 1);
    repeat (12) step();

`ifdef FETCH_PERF_EN
    @(negedge clk); #3;
    check("perf_bubble", perf_bubble_cnt, m_bubble);
    check("perf_flush", perf_flush_cnt, m_flush);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
